// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and scoreboard entry type for the hazard controller
package pipe_hazard_ctrl_pkg;

   // Bypass select value meaning "take the register file"; k > 0 selects stage Sk
   localparam int FWD_RF          = 0;
   localparam int DEF_NSTAGE      = 3;
   localparam int DEF_REDIR_STAGE = 2;
   // Extra stages a load needs before its data exists
   localparam int LAT_LOAD        = 1;
   localparam int RA_W            = 5;
   localparam int LAT_W           = 3;

   typedef struct packed {
      logic             valid;
      logic [RA_W-1:0]  rd;
      logic [LAT_W-1:0] cnt;
   } sb_entry_t;

   // Countdown to result availability, held at zero once the result exists
   function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
      return (v != '0) ? v - LAT_W'(1) : '0;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID-side, bypass and counter signals between the pipeline and the hazard controller
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int SELW   = $clog2(NSTAGE + 1)
) ();

   logic                   id_valid;
   logic [RA_W-1:0]        id_rs1;
   logic [RA_W-1:0]        id_rs2;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic [RA_W-1:0]        id_rd;
   logic                   id_we;
   logic [LAT_W-1:0]       id_lat;
   logic [XLEN-1:0]        rs1_rf;
   logic [XLEN-1:0]        rs2_rf;
   logic [NSTAGE*XLEN-1:0] stage_data;
   logic                   redirect;
   logic [XLEN-1:0]        rs1_fwd;
   logic [XLEN-1:0]        rs2_fwd;
   logic [SELW-1:0]        fwd_sel_rs1;
   logic [SELW-1:0]        fwd_sel_rs2;
   logic                   stall;
   logic                   flush;
   logic [31:0]            stall_cnt;
   logic [31:0]            flush_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_lat,
             rs1_rf, rs2_rf, stage_data, redirect,
      input  rs1_fwd, rs2_fwd, fwd_sel_rs1, fwd_sel_rs2, stall, flush, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_lat,
             rs1_rf, rs2_rf, stage_data, redirect,
      output rs1_fwd, rs2_fwd, fwd_sel_rs1, fwd_sel_rs2, stall, flush, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// rtl/pipe_hazard_ctrl_fwd_select.sv - youngest-match bypass select and data mux for one source operand
module pipe_hazard_ctrl_fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NSTAGE = DEF_NSTAGE,
   parameter int SELW   = $clog2(NSTAGE + 1)
) (
   input  logic [RA_W-1:0]        rs_i,
   input  logic [NSTAGE-1:0]      ent_valid_i,
   input  logic [NSTAGE*RA_W-1:0] ent_rd_i,
   input  logic [NSTAGE-1:0]      ent_ready_i,
   input  logic [XLEN-1:0]        rf_data_i,
   input  logic [NSTAGE*XLEN-1:0] stage_data_i,
   output logic [SELW-1:0]        sel_o,
   output logic                   ready_o,
   output logic [XLEN-1:0]        data_o
);

   // Walk oldest to youngest so the youngest matching stage has the final word
   always_comb begin
      sel_o   = SELW'(FWD_RF);
      ready_o = 1'b1;
      data_o  = rf_data_i;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         if (ent_valid_i[k] && (ent_rd_i[k*RA_W +: RA_W] == rs_i) && (rs_i != '0)) begin
            if (ent_ready_i[k]) begin
               sel_o   = SELW'(k + 1);
               ready_o = 1'b1;
               data_o  = stage_data_i[k*XLEN +: XLEN];
            end else begin
               sel_o   = SELW'(FWD_RF);
               ready_o = 1'b0;
               data_o  = rf_data_i;
            end
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - in-flight destination scoreboard driving operand bypass, stall, flush and perf counters
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NSTAGE      = DEF_NSTAGE,
   parameter int REDIR_STAGE = DEF_REDIR_STAGE
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int SELW = $clog2(NSTAGE + 1);

   sb_entry_t              ent_q [NSTAGE];
   sb_entry_t              ent_d [NSTAGE];
   logic [NSTAGE-1:0]      ent_valid;
   logic [NSTAGE*RA_W-1:0] ent_rd;
   logic [NSTAGE-1:0]      ent_ready;
   logic                   rs1_ready;
   logic                   rs2_ready;
   logic                   stall;
   logic [31:0]            stall_cnt_q;
   logic [31:0]            stall_cnt_d;
   logic [31:0]            flush_cnt_q;
   logic [31:0]            flush_cnt_d;

   // Flatten the scoreboard into the vectors the operand selectors consume
   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      ent_ready = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         ent_valid[k]              = ent_q[k].valid;
         ent_rd[k*RA_W +: RA_W]    = ent_q[k].rd;
         ent_ready[k]              = (ent_q[k].cnt == '0);
      end
   end

   pipe_hazard_ctrl_fwd_select #(.XLEN(XLEN), .NSTAGE(NSTAGE), .SELW(SELW)) u_sel_rs1 (
      .rs_i         (bus.id_rs1),
      .ent_valid_i  (ent_valid),
      .ent_rd_i     (ent_rd),
      .ent_ready_i  (ent_ready),
      .rf_data_i    (bus.rs1_rf),
      .stage_data_i (bus.stage_data),
      .sel_o        (bus.fwd_sel_rs1),
      .ready_o      (rs1_ready),
      .data_o       (bus.rs1_fwd)
   );

   pipe_hazard_ctrl_fwd_select #(.XLEN(XLEN), .NSTAGE(NSTAGE), .SELW(SELW)) u_sel_rs2 (
      .rs_i         (bus.id_rs2),
      .ent_valid_i  (ent_valid),
      .ent_rd_i     (ent_rd),
      .ent_ready_i  (ent_ready),
      .rf_data_i    (bus.rs2_rf),
      .stage_data_i (bus.stage_data),
      .sel_o        (bus.fwd_sel_rs2),
      .ready_o      (rs2_ready),
      .data_o       (bus.rs2_fwd)
   );

   // Redirect wins over stall: the killed ID instruction must not hold the front end
   always_comb begin
      stall = bus.id_valid & ~bus.redirect &
              ((bus.id_use_rs1 & ~rs1_ready) | (bus.id_use_rs2 & ~rs2_ready));
   end

   assign bus.stall     = stall;
   assign bus.flush     = bus.redirect;
   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

   // Unconditional shift; S1 takes ID unless it is stalled or killed, younger stages die on redirect
   always_comb begin
      ent_d[0].valid = bus.id_valid & bus.id_we & (bus.id_rd != '0) & ~stall & ~bus.redirect;
      ent_d[0].rd    = bus.id_rd;
      ent_d[0].cnt   = bus.id_lat;
      for (int k = 1; k < NSTAGE; k++) begin
         ent_d[k].valid = ent_q[k-1].valid & ~(bus.redirect & (k < REDIR_STAGE));
         ent_d[k].rd    = ent_q[k-1].rd;
         ent_d[k].cnt   = sat_dec(ent_q[k-1].cnt);
      end
   end

   // Event counters wrap naturally at 2^32
   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(stall);
      flush_cnt_d = flush_cnt_q + 32'(bus.redirect);
   end

   // Scoreboard and counter state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NSTAGE; k++) begin
            ent_q[k] <= '0;
         end
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int k = 0; k < NSTAGE; k++) begin
            ent_q[k] <= ent_d[k];
         end
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vectors for the pipeline hazard and bypass controller
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

   localparam logic [31:0] D_S1 = 32'h1111_0001;
   localparam logic [31:0] D_S2 = 32'h2222_0002;
   localparam logic [31:0] D_S3 = 32'h3333_0003;
   localparam logic [31:0] RF1  = 32'hAAAA_0000;
   localparam logic [31:0] RF2  = 32'hBBBB_0000;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   pipe_hazard_ctrl_if #(.XLEN(32), .NSTAGE(3)) bus ();

   pipe_hazard_ctrl #(.XLEN(32), .NSTAGE(3), .REDIR_STAGE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rd, input logic we, input logic [2:0] lat,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
      bus.id_valid   = v;
      bus.id_rd      = rd;
      bus.id_we      = we;
      bus.id_lat     = lat;
      bus.id_rs1     = rs1;
      bus.id_rs2     = rs2;
      bus.id_use_rs1 = u1;
      bus.id_use_rs2 = u2;
   endtask

   // Advance to just after the next rising edge, where new ID inputs are applied
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      set_id(1'b0, 5'd0, 1'b0, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.rs1_rf     = RF1;
      bus.rs2_rf     = RF2;
      bus.stage_data = {D_S3, D_S2, D_S1};
      bus.redirect   = 1'b0;
      #2;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_sel1", 32'(bus.fwd_sel_rs1), 32'd0);
      check("rst_stall_cnt", bus.stall_cnt, 32'd0);
      check("rst_flush_cnt", bus.flush_cnt, 32'd0);
      check("rst_flush", 32'(bus.flush), 32'd0);
      next_cycle();
      rst = 1'b1;

      // ALU producer x5 then consumer add x6,x5,x1
      set_id(1'b1, 5'd5, 1'b1, 3'd0, 5'd1, 5'd2, 1'b1, 1'b1);
      #1 check("alu_prod_stall", 32'(bus.stall), 32'd0);
      next_cycle();
      set_id(1'b1, 5'd6, 1'b1, 3'd0, 5'd5, 5'd1, 1'b1, 1'b1);
      #1;
      check("alu_sel1", 32'(bus.fwd_sel_rs1), 32'd1);
      check("alu_fwd1", bus.rs1_fwd, D_S1);
      check("alu_sel2", 32'(bus.fwd_sel_rs2), 32'd0);
      check("alu_fwd2", bus.rs2_fwd, RF2);
      check("alu_stall", 32'(bus.stall), 32'd0);
      next_cycle();

      // Load-use: lw x6 then add x7,x6,x6
      set_id(1'b1, 5'd6, 1'b1, 3'(LAT_LOAD), 5'd2, 5'd0, 1'b1, 1'b0);
      #1 check("lw_stall", 32'(bus.stall), 32'd0);
      next_cycle();
      set_id(1'b1, 5'd7, 1'b1, 3'd0, 5'd6, 5'd6, 1'b1, 1'b1);
      #1;
      check("lu_stall", 32'(bus.stall), 32'd1);
      check("lu_stall_cnt0", bus.stall_cnt, 32'd0);
      next_cycle();
      #1;
      check("lu_stall_after", 32'(bus.stall), 32'd0);
      check("lu_stall_cnt1", bus.stall_cnt, 32'd1);
      check("lu_sel1", 32'(bus.fwd_sel_rs1), 32'd2);
      check("lu_sel2", 32'(bus.fwd_sel_rs2), 32'd2);
      check("lu_fwd1", bus.rs1_fwd, D_S2);
      check("lu_fwd2", bus.rs2_fwd, D_S2);
      next_cycle();

      // x0: addi x0 then a consumer of x0
      set_id(1'b1, 5'd0, 1'b1, 3'd0, 5'd3, 5'd0, 1'b1, 1'b0);
      next_cycle();
      bus.rs1_rf = 32'd0;
      set_id(1'b1, 5'd8, 1'b0, 3'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      #1;
      check("x0_sel1", 32'(bus.fwd_sel_rs1), 32'd0);
      check("x0_fwd1", bus.rs1_fwd, 32'd0);
      check("x0_stall", 32'(bus.stall), 32'd0);
      next_cycle();
      bus.rs1_rf = RF1;

      // Priority: x9 in S1 and S3, x10 in S2
      set_id(1'b1, 5'd9, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd10, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd9, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd9, 5'd10, 1'b1, 1'b1);
      #1;
      check("prio_sel1", 32'(bus.fwd_sel_rs1), 32'd1);
      check("prio_fwd1", bus.rs1_fwd, D_S1);
      check("prio_sel2", 32'(bus.fwd_sel_rs2), 32'd2);
      check("prio_fwd2", bus.rs2_fwd, D_S2);
      next_cycle();

      // Redirect with a younger load in S1 and a dependent in ID
      set_id(1'b1, 5'd11, 1'b1, 3'(LAT_LOAD), 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd12, 1'b1, 3'd0, 5'd11, 5'd0, 1'b1, 1'b0);
      bus.redirect = 1'b1;
      #1;
      check("redir_flush", 32'(bus.flush), 32'd1);
      check("redir_stall", 32'(bus.stall), 32'd0);
      check("redir_flush_cnt0", bus.flush_cnt, 32'd0);
      next_cycle();
      bus.redirect = 1'b0;
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd11, 5'd12, 1'b1, 1'b1);
      #1;
      check("redir_s2_empty", 32'(bus.fwd_sel_rs1), 32'd0);
      check("redir_s1_empty", 32'(bus.fwd_sel_rs2), 32'd0);
      check("redir_after_stall", 32'(bus.stall), 32'd0);
      check("redir_after_flush", 32'(bus.flush), 32'd0);
      check("redir_flush_cnt1", bus.flush_cnt, 32'd1);
      check("redir_stall_cnt", bus.stall_cnt, 32'd1);
      next_cycle();

      // Latency-2 producer: consumer stalls twice, then forwards from S3
      set_id(1'b1, 5'd16, 1'b1, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd16, 5'd0, 1'b1, 1'b0);
      #1 check("lat2_stall_a", 32'(bus.stall), 32'd1);
      next_cycle();
      #1 check("lat2_stall_b", 32'(bus.stall), 32'd1);
      next_cycle();
      #1;
      check("lat2_stall_c", 32'(bus.stall), 32'd0);
      check("lat2_sel1", 32'(bus.fwd_sel_rs1), 32'd3);
      check("lat2_fwd1", bus.rs1_fwd, D_S3);
      check("lat2_stall_cnt", bus.stall_cnt, 32'd3);
      next_cycle();

      // Reset mid-operation with three valid entries
      set_id(1'b1, 5'd13, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd14, 1'b1, 3'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd15, 1'b1, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd15, 5'd14, 1'b1, 1'b1);
      #1;
      check("pre_rst_stall", 32'(bus.stall), 32'd1);
      check("pre_rst_sel2", 32'(bus.fwd_sel_rs2), 32'd2);
      rst = 1'b0;
      #1;
      check("mid_rst_stall", 32'(bus.stall), 32'd0);
      check("mid_rst_sel1", 32'(bus.fwd_sel_rs1), 32'd0);
      check("mid_rst_sel2", 32'(bus.fwd_sel_rs2), 32'd0);
      check("mid_rst_stall_cnt", bus.stall_cnt, 32'd0);
      check("mid_rst_flush_cnt", bus.flush_cnt, 32'd0);
      bus.redirect = 1'b1;
      #1 check("mid_rst_flush", 32'(bus.flush), 32'd1);
      bus.redirect = 1'b0;
      next_cycle();
      rst = 1'b1;
      set_id(1'b1, 5'd0, 1'b0, 3'd0, 5'd13, 5'd14, 1'b1, 1'b1);
      #1;
      check("post_rst_sel1", 32'(bus.fwd_sel_rs1), 32'd0);
      check("post_rst_sel2", 32'(bus.fwd_sel_rs2), 32'd0);
      check("post_rst_fwd1", bus.rs1_fwd, RF1);
      check("post_rst_stall", 32'(bus.stall), 32'd0);
      next_cycle();
      check("post_rst_stall_cnt", bus.stall_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
